// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
// Contains the opcodes, the funct3 access codes, the LSU state encodings and
// small helpers for funct3 legality and byte-lane masks.
package load_store_unit_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] LSU_IDLE   = 2'd0;
    localparam logic [1:0] LSU_FIRST  = 2'd1;
    localparam logic [1:0] LSU_SECOND = 2'd2;
    localparam logic [1:0] LSU_DONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = LSU_IDLE,
        ST_FIRST  = LSU_FIRST,
        ST_SECOND = LSU_SECOND,
        ST_DONE   = LSU_DONE
    } lsu_state_e;

    // Loads accept the signed and unsigned byte/half codes plus LW;
    // stores accept only SB/SH/SW.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_LB, F3_LH, F3_LW: ok = 1'b1;
            F3_LBU, F3_LHU:      ok = !is_store;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte lanes touched by an access of size code sz at offset off, over two
    // consecutive words: [3:0] first word, [7:4] second word.
    function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [1:0] sz);
        logic [7:0] ones;
        case (sz)
            2'b00:   ones = 8'h01;
            2'b01:   ones = 8'h03;
            default: ones = 8'h0F;
        endcase
        return ones << off;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extender.sv
// load_extender: aligns and extends load data.
// Ports:
//   i_buf    {hi_word, lo_word} as read from memory
//   i_off    byte offset of the access inside the low word
//   i_funct3 access size / signedness
//   o_data   right-aligned, sign- or zero-extended result
module load_extender
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] i_buf,
    input  logic [1:0]        i_off,
    input  logic [2:0]        i_funct3,
    output logic [XLEN-1:0]   o_data
);

    logic [XLEN-1:0] w_word;

    assign w_word = i_buf[{i_off, 3'b000} +: XLEN];

    always_comb begin
        o_data = w_word;
        case (i_funct3)
            F3_LB:   o_data = {{(XLEN-8){w_word[7]}}, w_word[7:0]};
            F3_LH:   o_data = {{(XLEN-16){w_word[15]}}, w_word[15:0]};
            F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_word[7:0]};
            F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_word[15:0]};
            default: o_data = w_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: runs one or two word-aligned bus transactions for a
// load/store and returns extended load data.
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_start, i_opcode,         request from execute (sampled in IDLE only)
//   i_funct3, i_address,
//   i_store_data
//   o_busy, o_done, o_error    status; done is a one-cycle pulse, error valid with done
//   o_load_data                extended load result, held until the next done
//   o_mem_req/we/addr/wmask/wdata, i_mem_ready, i_mem_rdata   data-memory bus
//   o_dbg_state                current FSM state
// Bus handshake: a transaction completes on a cycle where o_mem_req and
// i_mem_ready are both 1; until then every o_mem_* output holds its value.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_address,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_error,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [3:0]      o_mem_wmask,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_ready,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic [1:0]      o_dbg_state
);

    lsu_state_e      r_state;
    logic [1:0]      r_off;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_sdata;
    logic            r_we;
    logic [XLEN-1:0] r_lo;
    logic            r_error;
    logic [XLEN-1:0] r_load_data;
    logic            r_mem_req;
    logic [XLEN-1:0] r_mem_addr;
    logic [3:0]      r_mem_wmask;
    logic [XLEN-1:0] r_mem_wdata;

    logic              w_is_load;
    logic              w_is_store;
    logic [7:0]        w_in_lanes;
    logic [2*XLEN-1:0] w_in_wide;
    logic [7:0]        w_lanes;
    logic [2*XLEN-1:0] w_wide;
    logic              w_split;
    logic [2*XLEN-1:0] w_ext_buf;
    logic [XLEN-1:0]   w_ext;

    assign w_is_load  = (i_opcode == OPC_LOAD);
    assign w_is_store = (i_opcode == OPC_STORE);

    // Lane masks and shifted store data span two words; the upper half is
    // what the second transaction of a split access uses.
    assign w_in_lanes = lane_mask(i_address[1:0], i_funct3[1:0]);
    assign w_in_wide  = {{XLEN{1'b0}}, i_store_data} << {i_address[1:0], 3'b000};
    assign w_lanes    = lane_mask(r_off, r_funct3[1:0]);
    assign w_wide     = {{XLEN{1'b0}}, r_sdata} << {r_off, 3'b000};
    assign w_split    = |w_lanes[7:4];

    // The result is registered on the edge that enters DONE, so the word
    // arriving in that cycle feeds the extender directly instead of going
    // through a hi buffer first. A non-split access never looks at the hi half.
    assign w_ext_buf = (r_state == ST_SECOND) ? {i_mem_rdata, r_lo}
                                              : {{XLEN{1'b0}}, i_mem_rdata};

    load_extender #(.XLEN(XLEN)) u_load_extender (
        .i_buf    (w_ext_buf),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_off       <= '0;
            r_funct3    <= '0;
            r_sdata     <= '0;
            r_we        <= 1'b0;
            r_lo        <= '0;
            r_error     <= 1'b0;
            r_load_data <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wmask <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && (w_is_load || w_is_store)) begin
                        if (f3_legal(w_is_store, i_funct3)) begin
                            r_off       <= i_address[1:0];
                            r_funct3    <= i_funct3;
                            r_sdata     <= i_store_data;
                            r_we        <= w_is_store;
                            r_error     <= 1'b0;
                            r_mem_req   <= 1'b1;
                            r_mem_addr  <= {i_address[XLEN-1:2], 2'b00};
                            r_mem_wmask <= w_in_lanes[3:0];
                            r_mem_wdata <= w_in_wide[XLEN-1:0];
                            r_state     <= ST_FIRST;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_FIRST: begin
                    if (i_mem_ready) begin
                        if (w_split) begin
                            r_lo        <= i_mem_rdata;
                            r_mem_addr  <= r_mem_addr + 32'd4;
                            r_mem_wmask <= w_lanes[7:4];
                            r_mem_wdata <= w_wide[2*XLEN-1:XLEN];
                            r_state     <= ST_SECOND;
                        end else begin
                            r_mem_req   <= 1'b0;
                            r_mem_wmask <= '0;
                            if (!r_we) begin
                                r_load_data <= w_ext;
                            end
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_SECOND: begin
                    if (i_mem_ready) begin
                        r_mem_req   <= 1'b0;
                        r_mem_wmask <= '0;
                        if (!r_we) begin
                            r_load_data <= w_ext;
                        end
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_error     = r_error;
    assign o_load_data = r_load_data;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wmask = r_mem_wmask;
    assign o_mem_wdata = r_mem_wdata;
    assign o_dbg_state = r_state;

endmodule
